// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues imem reads for the current PC and keeps
// returned words, tagged with their PC, in order for decode.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          pc_clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  output logic          fetch_stall,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_resp_valid,
  input  logic [DW-1:0] imem_resp_data,
  output logic          instr_valid,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    ent_pc   [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_filled;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;

  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] pend_cnt;
  logic [CW:0]   used;

  logic req_fire;
  logic resp_drop;
  logic resp_fill;
  logic resp_live;
  logic pop;

  assign used = {1'b0, alloc_cnt} + {1'b0, drop_cnt};

  assign imem_req_valid = reset && !redirect &&
                          (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fetch_stall    = !req_fire;

  // pend_cnt counts live requests still awaiting data
  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt == '0) &&
                     (pend_cnt != '0);
  assign resp_live = resp_drop || resp_fill;

  assign instr_valid = ent_filled[head_ptr];
  assign instr_data  = ent_data[head_ptr];
  assign instr_pc    = ent_pc[head_ptr];

  assign pop = instr_valid && instr_ready && !redirect;

  always_ff @(posedge pc_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
      end
      ent_filled <= '0;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      alloc_cnt  <= '0;
      drop_cnt   <= '0;
      pend_cnt   <= '0;
    end else if (redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
      end
      ent_filled <= '0;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      alloc_cnt  <= '0;
      pend_cnt   <= '0;
      // this cycle's response retires one of the in-flight reads
      drop_cnt   <= drop_cnt + pend_cnt - CW'(resp_live);
    end else begin
      if (req_fire) begin
        ent_pc[alloc_ptr]     <= pc_in;
        ent_filled[alloc_ptr] <= 1'b0;
        alloc_ptr             <= alloc_ptr + PW'(1);
      end
      if (resp_fill) begin
        ent_data[fill_ptr]   <= imem_resp_data;
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop) begin
        ent_filled[head_ptr] <= 1'b0;
        head_ptr             <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(req_fire) - CW'(resp_fill);
      drop_cnt  <= drop_cnt - CW'(resp_drop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register and
// fixed-latency instruction memory modelled around the DUT.
module tb_instr_fetch_unit;

  logic        pc_clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        redirect;
  logic        fetch_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .pc_clk          (pc_clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .redirect        (redirect),
    .fetch_stall     (fetch_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  initial pc_clk = 1'b0;
  always #5 pc_clk = ~pc_clk;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  typedef struct {
    bit          first;
    logic [31:0] pc0;
    int          lat;
    bit          ir;
    bit          mr;
    bit          rv;
    logic [31:0] addr;
    bit          st;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;

  mreq_t       q[$];
  vec_t        vecs[$];
  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  logic [31:0] rtgt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic add(bit first, logic [31:0] pc0, int l, bit ir,
                     bit mr, bit rv, logic [31:0] addr, bit st,
                     bit iv, logic [31:0] ipc);
    vec_t v;
    v.first = first; v.pc0 = pc0; v.lat = l;
    v.ir = ir; v.mr = mr; v.rv = rv; v.addr = addr;
    v.st = st; v.iv = iv; v.ipc = ipc;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge; leaves the DUT out of reset at
  // the same point in the cycle.
  task automatic do_reset(logic [31:0] pc0, int l);
    reset = 1'b0;
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    q.delete();
    pc_in = pc0;
    lat = l;
    cyc = 0;
    @(negedge pc_clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    @(posedge pc_clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(bit ir, bit mr, bit rd, logic [31:0] tgt);
    instr_ready = ir;
    imem_req_ready = mr;
    redirect = rd;
    rtgt = tgt;
    @(negedge pc_clk);
  endtask

  // Clock edge plus the PC register and memory model around the DUT
  task automatic adv();
    bit          f;
    bit          st;
    bit          rd;
    logic [31:0] a;
    mreq_t       m;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    st = fetch_stall;
    rd = redirect;
    @(posedge pc_clk);
    #1;
    cyc++;
    if (f) begin
      m.a = a;
      m.due = cyc + lat - 1;
      q.push_back(m);
    end
    if (rd) pc_in = rtgt;
    else if (!st) pc_in = pc_in + 32'd4;
    if (q.size() > 0 && q[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = q[0].a ^ TAG;
      void'(q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
    end
    redirect = 1'b0;
  endtask

  task automatic chk_out(string tag, bit iv, logic [31:0] ipc);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'(iv));
    if (iv) begin
      chk({tag, "_instr_pc"}, instr_pc, ipc);
      chk({tag, "_instr_data"}, instr_data, ipc ^ TAG);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    pc_in = '0;
    redirect = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    instr_ready = 1'b0;
    rtgt = '0;
    lat = 1;
    cyc = 0;

    // Streaming, one instruction per cycle
    add(1, 32'h0, 1, 1, 1, 1, 32'h00, 0, 0, 32'h0);
    add(0, 32'h0, 1, 1, 1, 1, 32'h04, 0, 0, 32'h0);
    add(0, 32'h0, 1, 1, 1, 1, 32'h08, 0, 1, 32'h0);
    add(0, 32'h0, 1, 1, 1, 1, 32'h0C, 0, 1, 32'h4);
    add(0, 32'h0, 1, 1, 1, 1, 32'h10, 0, 1, 32'h8);
    add(0, 32'h0, 1, 1, 1, 1, 32'h14, 0, 1, 32'hC);
    // Decode stalled: buffer fills, then drains
    add(1, 32'h0, 1, 0, 1, 1, 32'h00, 0, 0, 32'h0);
    add(0, 32'h0, 1, 0, 1, 1, 32'h04, 0, 0, 32'h0);
    add(0, 32'h0, 1, 0, 1, 1, 32'h08, 0, 1, 32'h0);
    add(0, 32'h0, 1, 0, 1, 1, 32'h0C, 0, 1, 32'h0);
    add(0, 32'h0, 1, 0, 1, 0, 32'h10, 1, 1, 32'h0);
    add(0, 32'h0, 1, 0, 1, 0, 32'h10, 1, 1, 32'h0);
    add(0, 32'h0, 1, 1, 1, 0, 32'h10, 1, 1, 32'h0);
    add(0, 32'h0, 1, 1, 1, 1, 32'h10, 0, 1, 32'h4);
    add(0, 32'h0, 1, 1, 1, 1, 32'h14, 0, 1, 32'h8);
    add(0, 32'h0, 1, 1, 1, 1, 32'h18, 0, 1, 32'hC);
    add(0, 32'h0, 1, 1, 1, 1, 32'h1C, 0, 1, 32'h10);
    add(0, 32'h0, 1, 1, 1, 1, 32'h20, 0, 1, 32'h14);
    // Memory not ready for three cycles
    add(1, 32'h20, 1, 1, 0, 1, 32'h20, 1, 0, 32'h0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 1, 0, 32'h0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 1, 0, 32'h0);
    add(0, 32'h20, 1, 1, 1, 1, 32'h20, 0, 0, 32'h0);
    add(0, 32'h20, 1, 1, 1, 1, 32'h24, 0, 0, 32'h0);
    add(0, 32'h20, 1, 1, 1, 1, 32'h28, 0, 1, 32'h20);

    @(posedge pc_clk);
    #1;
    foreach (vecs[i]) begin
      if (vecs[i].first) do_reset(vecs[i].pc0, vecs[i].lat);
      drive(vecs[i].ir, vecs[i].mr, 1'b0, '0);
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid),
          32'(vecs[i].rv));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      chk($sformatf("v%0d_stall", i), 32'(fetch_stall),
          32'(vecs[i].st));
      chk_out($sformatf("v%0d", i), vecs[i].iv, vecs[i].ipc);
      adv();
    end

    // Redirect with 0x8/0xC in flight, 0x8 returning that cycle
    do_reset(32'h0, 2);
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 0, '0);
      if (c == 3) chk_out("rd_pre", 1, 32'h0);
      adv();
    end
    drive(1, 1, 1, 32'h100);
    chk("rd_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd_stall", 32'(fetch_stall), 32'd1);
    adv();
    drive(1, 1, 0, '0);
    chk("rd_new_addr", imem_req_addr, 32'h100);
    chk("rd_new_valid", 32'(imem_req_valid), 32'd1);
    chk_out("rd_c5", 0, '0);
    adv();
    for (int c = 6; c < 8; c++) begin
      drive(1, 1, 0, '0);
      chk_out($sformatf("rd_c%0d", c), 0, '0);
      adv();
    end
    drive(1, 1, 0, '0);
    chk_out("rd_first", 1, 32'h100);
    adv();

    // Asynchronous reset with three filled entries
    do_reset(32'h0, 1);
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, '0);
      adv();
    end
    chk_out("mr_pre", 1, 32'h0);
    reset = 1'b0;
    #1;
    chk("mr_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mr_stall", 32'(fetch_stall), 32'd1);
    chk("mr_instr_valid", 32'(instr_valid), 32'd0);
    chk("mr_instr_data", instr_data, 32'd0);
    chk("mr_instr_pc", instr_pc, 32'd0);
    q.delete();
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    pc_in = '0;
    cyc = 0;
    @(posedge pc_clk);
    #1;
    reset = 1'b1;
    drive(1, 1, 0, '0);
    chk("mr_post_addr", imem_req_addr, 32'h0);
    chk("mr_post_valid", 32'(imem_req_valid), 32'd1);
    chk_out("mr_post_c0", 0, '0);
    adv();
    drive(1, 1, 0, '0);
    chk_out("mr_post_c1", 0, '0);
    adv();
    drive(1, 1, 0, '0);
    chk_out("mr_post_c2", 1, 32'h0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
